ysyx_22041071_if_axi_read: RTL and testbench
============================================

# ysyx_22041071_if_axi_read

Instruction-fetch read master directly downstream of the PC stage. Accepts one fetch request (address, burst length, size) per transaction and drives it onto the AXI4 AR channel. It collects the R-channel response, selects the 32-bit instruction from the 64-bit data beat, and presents it to decode over a valid/ready handshake. One outstanding transaction at a time; a flush input discards in-flight results on redirect.

## Interface
- ADDR_W, 64, fetch address width
- DATA_W, 64, AXI read data width
- LEN_W, 8, AXI arlen width (matches ysyx_22041071_AXI_LEN_WIDTH)
- ID_W, 4, AXI arid/rid width
- FETCH_ID, 0, constant arid value
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately on assertion
- req_valid  in  1  fetch request from PC stage
- req_ready  out  1  block can accept a request (reset 1)
- req_addr  in  ADDR_W  fetch address
- req_len  in  LEN_W  burst length minus one
- req_size  in  2  beat size code; zero-extended to arsize
- flush  in  1  discard current fetch (redirect)
- arvalid  out  1  (reset 0)
- arready  in  1
- araddr  out  ADDR_W  (reset 0)
- arlen  out  LEN_W  (reset 0)
- arsize  out  3  (reset 0)
- arburst  out  2  constant 2'b01 INCR
- arid  out  ID_W  constant FETCH_ID
- rvalid  in  1
- rready  out  1  (reset 0)
- rdata  in  DATA_W
- rresp  in  2
- rlast  in  1
- inst_valid  out  1  instruction available (reset 0)
- inst_ready  in  1  decode accepts
- inst  out  32  instruction (reset 0)
- inst_pc  out  ADDR_W  address of inst (reset 0)
- inst_err  out  1  bus error on this fetch (reset 0)

## Operation
- FSM states: IDLE, ADDR, DATA, OUT. Reset → IDLE.
- IDLE: req_ready=1. On req_valid, register addr/len/size into AR outputs, set arvalid=1 → ADDR.
- ADDR: arvalid held with stable payload until arready. On arready: arvalid=0, rready=1 → DATA.
- DATA: rready=1. First beat (beat counter 0) is captured: inst = addr[2] ? rdata[63:32] : rdata[31:0]; inst_pc = registered addr. Later beats are drained and ignored. On rvalid & rlast: rready=0 → OUT; inst_valid=1 unless dropped.
- OUT: inst_valid held with stable payload until inst_ready → IDLE.
- Beat counter is LEN_W bits, cleared on AR handshake, incremented per accepted beat; if rlast arrives before the counter reaches arlen, the response is still terminated by rlast.
- Flush: IDLE: no effect. ADDR: arvalid is not retracted (AXI rule); a drop flag is set. DATA with drop flag: beats are drained, OUT is skipped, and the FSM returns to IDLE after rlast. OUT: inst_valid clears next cycle → IDLE. Flush and inst_ready in the same OUT cycle count as a handshake, and the FSM returns to IDLE.
- Flush in the same cycle as the IDLE request: the request is accepted (the PC stage supplies the redirected address).

## Timing
- Request accepted at cycle 0 → arvalid at cycle 1.
- arready at cycle 1 → rready at cycle 2.
- rvalid & rlast at cycle 2 → inst_valid at cycle 3.
- Minimum request-to-instruction latency: 3 cycles. Throughput: one fetch per 4 cycles at best.
- req_ready is 0 from the cycle after acceptance until the cycle after the OUT handshake.
- Reset asserted mid-transaction: every output goes to its reset value asynchronously and the FSM returns to IDLE. Outstanding AXI beats after reset are the interconnect's responsibility (system-wide reset).

## Configuration
- YSYX_22041071_FETCH_RESP_CHK_EN defined:
  - rresp of the captured beat is checked.
  - Any value ≠ OKAY (2'b00) sets inst_err=1 and forces inst to NOP 32'h00000013. inst_pc is preserved.
  - An error on a drained beat is ORed into inst_err.
- Not defined: inst_err is tied to 0 and rresp is ignored.

## Structure
- Shared define package holds:
  - FSM state encodings
  - AXI burst constant INCR = 2'b01
  - RESP_OKAY = 2'b00
  - NOP = 32'h00000013
  - width defaults, reusing the existing SIZE_D and AXI_LEN_WIDTH definitions
- One combinational sub-module, ysyx_22041071_inst_align: selects the 32-bit half of rdata by addr[2].

## Test plan
- Single fetch: addr 0x80000004, len 0, size 3; arready immediate; rdata 0x00100093_00000013, rlast → inst=0x00100093, inst_pc=0x80000004, inst_valid at cycle 3.
- Backpressure: arready low 3 cycles, inst_ready low 2 cycles → araddr/arvalid stable throughout; inst stable; req_ready=0 until handshake.
- Burst len 1: two beats, only the first (addr 0x80000000 → low word) returned; FSM returns to IDLE after rlast.
- Flush in ADDR: arvalid stays until arready; the R beat is drained; inst_valid never asserts; next req accepted.
- Error response with macro: rresp=2'b10 → inst=0x00000013, inst_err=1. Without macro: inst_err=0 and raw data is returned.
- Async reset in DATA: reset mid-cycle → rready, inst_valid=0 immediately; req_ready=1 after release.

Source files
------------

// File: rtl/ysyx_22041071_if_axi_read_pkg.sv
// rtl/ysyx_22041071_if_axi_read_pkg.sv - shared defines for the instruction-fetch AXI read master
// Optional feature macro: YSYX_22041071_FETCH_RESP_CHK_EN (fetch response checking).
package ysyx_22041071_if_axi_read_pkg;

  localparam int YSYX_22041071_SIZE_D         = 64;
  localparam int YSYX_22041071_AXI_LEN_WIDTH  = 8;
  localparam int YSYX_22041071_AXI_ID_WIDTH   = 4;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [31:0] INST_NOP       = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_ADDR = 2'd1,
    FETCH_DATA = 2'd2,
    FETCH_OUT  = 2'd3
  } fetch_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_22041071_inst_align.sv
// rtl/ysyx_22041071_inst_align.sv - picks the 32-bit instruction out of a 64-bit read beat
module ysyx_22041071_inst_align
  import ysyx_22041071_if_axi_read_pkg::*;
#(
  parameter int DATA_W = YSYX_22041071_SIZE_D
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic              sel_hi,
  output logic [31:0]       word
);

  always_comb begin
    word = sel_hi ? rdata[63:32] : rdata[31:0];
  end

endmodule

// File: rtl/ysyx_22041071_if_axi_read.sv
// rtl/ysyx_22041071_if_axi_read.sv - single-outstanding instruction fetch read master on AXI4 AR/R
// Optional feature macro: YSYX_22041071_FETCH_RESP_CHK_EN (rresp check, NOP substitution, inst_err).
module ysyx_22041071_if_axi_read
  import ysyx_22041071_if_axi_read_pkg::*;
#(
  parameter int ADDR_W   = YSYX_22041071_SIZE_D,
  parameter int DATA_W   = YSYX_22041071_SIZE_D,
  parameter int LEN_W    = YSYX_22041071_AXI_LEN_WIDTH,
  parameter int ID_W     = YSYX_22041071_AXI_ID_WIDTH,
  parameter int FETCH_ID = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [1:0]        req_size,
  input  logic              flush,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);

  fetch_state_e       state, state_nxt;
  logic [LEN_W-1:0]   beat_cnt;
  logic               drop;
  logic [31:0]        aligned_word;
  logic               beat_fire;
  logic               first_beat;

  assign arburst    = AXI_BURST_INCR;
  assign arid       = ID_W'(FETCH_ID);
  assign beat_fire  = (state == FETCH_DATA) && rvalid;
  assign first_beat = (beat_cnt == '0);

  ysyx_22041071_inst_align #(
    .DATA_W (DATA_W)
  ) u_inst_align (
    .rdata  (rdata),
    .sel_hi (araddr[2]),
    .word   (aligned_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH_IDLE: if (req_valid)  state_nxt = FETCH_ADDR;
      FETCH_ADDR: if (arready)    state_nxt = FETCH_DATA;
      // A flush landing on the rlast beat still suppresses the result.
      FETCH_DATA: if (rvalid && rlast) state_nxt = (drop || flush) ? FETCH_IDLE : FETCH_OUT;
      FETCH_OUT:  if (inst_ready || flush) state_nxt = FETCH_IDLE;
      default:    state_nxt = FETCH_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    unique case (state)
      FETCH_IDLE: req_ready  = 1'b1;
      FETCH_ADDR: arvalid    = 1'b1;
      FETCH_DATA: rready     = 1'b1;
      FETCH_OUT:  inst_valid = 1'b1;
      default:    req_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr   <= '0;
      arlen    <= '0;
      arsize   <= '0;
      drop     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (state == FETCH_IDLE && req_valid) begin
        araddr <= req_addr;
        arlen  <= req_len;
        arsize <= {1'b0, req_size};
        drop   <= 1'b0;
      end
      // AR cannot be retracted, so a redirect is remembered and applied to the R data.
      if ((state == FETCH_ADDR || state == FETCH_DATA) && flush) begin
        drop <= 1'b1;
      end
      if (state == FETCH_ADDR && arready) begin
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst    <= '0;
      inst_pc <= '0;
    end else if (beat_fire && first_beat) begin
      inst_pc <= araddr;
`ifdef YSYX_22041071_FETCH_RESP_CHK_EN
      inst    <= resp_is_err(rresp) ? INST_NOP : aligned_word;
`else
      inst    <= aligned_word;
`endif
    end
  end

`ifdef YSYX_22041071_FETCH_RESP_CHK_EN
  logic err_q;

  // Errors on drained beats accumulate into the captured beat's status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (beat_fire) begin
      err_q <= first_beat ? resp_is_err(rresp) : (err_q | resp_is_err(rresp));
    end
  end

  assign inst_err = err_q;
`else
  logic unused_rresp;

  assign unused_rresp = ^rresp;
  assign inst_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041071_if_axi_read.sv
// tb/tb_ysyx_22041071_if_axi_read.sv - scoreboard bench for the instruction-fetch AXI read master
module tb_ysyx_22041071_if_axi_read;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [1:0]  req_size;
  logic        flush;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_err;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  ysyx_22041071_if_axi_read dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_size   (req_size),
    .flush      (flush),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arid       (arid),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_err   (inst_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [63:0] addr, input logic [63:0] d);
    return addr[2] ? d[63:32] : d[31:0];
  endfunction

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_inst", inst, e.inst);
        check_eq("sb_pc", inst_pc, e.pc);
        check_eq("sb_err", inst_err, e.err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // flush_out: 0 none, 1 flush alone in OUT, 2 flush together with inst_ready
  task automatic run_fetch(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] size,
                           input int ar_wait, input int nbeats, input logic [63:0] d0,
                           input logic [1:0] r0, input logic [1:0] rn, input int inst_wait,
                           input bit flush_req, input bit flush_addr, input int flush_out);
    exp_t e;
    e.pc = addr;
`ifdef YSYX_22041071_FETCH_RESP_CHK_EN
    e.err  = (r0 != 2'b00) || (nbeats > 1 && rn != 2'b00);
    e.inst = (r0 != 2'b00) ? 32'h00000013 : exp_word(addr, d0);
`else
    e.err  = 1'b0;
    e.inst = exp_word(addr, d0);
`endif
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_len = len; req_size = size; flush = flush_req;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    req_addr = {$urandom, $urandom}; req_len = 8'($urandom); req_size = 2'($urandom);
    for (int i = 0; i < ar_wait; i++) begin
      check_eq("arvalid_hold", arvalid, 1);
      check_eq("araddr_hold", araddr, addr);
      check_eq("req_ready_busy", req_ready, 0);
      flush = flush_addr && (i == 0);
      tick();
      flush = 1'b0;
    end
    check_eq("arvalid", arvalid, 1);
    check_eq("araddr", araddr, addr);
    check_eq("arlen", arlen, len);
    check_eq("arsize", arsize, {1'b0, size});
    check_eq("arburst", arburst, 2'b01);
    check_eq("arid", arid, 0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("rready", rready, 1);
    check_eq("arvalid_drop", arvalid, 0);
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1'b1;
      rdata  = (b == 0) ? d0 : {$urandom, $urandom};
      rresp  = (b == 0) ? r0 : rn;
      rlast  = (b == nbeats - 1);
      if (b == nbeats - 1 && !flush_addr && flush_out != 1) sb.push_back(e);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (flush_addr) begin
      check_eq("drop_no_inst", inst_valid, 0);
      check_eq("drop_idle", req_ready, 1);
      check_eq("drop_rready", rready, 0);
      return;
    end
    check_eq("inst_valid", inst_valid, 1);
    check_eq("rready_off", rready, 0);
    for (int w = 0; w < inst_wait; w++) begin
      check_eq("inst_hold", inst, e.inst);
      check_eq("inst_valid_hold", inst_valid, 1);
      check_eq("req_ready_out", req_ready, 0);
      tick();
    end
    flush = (flush_out != 0);
    inst_ready = (flush_out != 1);
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    check_eq("inst_valid_clr", inst_valid, 0);
    check_eq("req_ready_back", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_addr = 0; req_len = 0; req_size = 0; flush = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; inst_ready = 0;
    tick();
    tick();
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_araddr", araddr, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst", inst, 0);
    check_eq("rst_inst_pc", inst_pc, 0);
    check_eq("rst_inst_err", inst_err, 0);
    reset = 1'b0;
    tick();

    run_fetch(64'h80000004, 8'd0, 2'd3, 0, 1, 64'h00100093_00000013, 2'b00, 2'b00, 0, 0, 0, 0);
    run_fetch(64'h80000010, 8'd0, 2'd2, 3, 1, 64'h11111111_22222222, 2'b00, 2'b00, 2, 0, 0, 0);
    run_fetch(64'h80000000, 8'd1, 2'd3, 0, 2, 64'hdeadbeef_00a00513, 2'b00, 2'b00, 0, 0, 0, 0);
    run_fetch(64'h80000020, 8'd0, 2'd3, 2, 1, 64'haaaaaaaa_bbbbbbbb, 2'b00, 2'b00, 0, 0, 1, 0);
    run_fetch(64'h80000008, 8'd0, 2'd3, 0, 1, 64'h00000000_00500593, 2'b10, 2'b00, 0, 0, 0, 0);
    run_fetch(64'h8000000c, 8'd1, 2'd3, 1, 2, 64'h00c00613_12345678, 2'b00, 2'b11, 1, 0, 0, 0);
    run_fetch(64'h80000100, 8'd3, 2'd3, 0, 2, 64'hcafef00d_0badf00d, 2'b00, 2'b00, 0, 0, 0, 0);
    run_fetch(64'h80000104, 8'd0, 2'd3, 0, 1, 64'h01020304_05060708, 2'b00, 2'b00, 1, 0, 0, 1);
    run_fetch(64'h80000108, 8'd0, 2'd3, 0, 1, 64'h0a0b0c0d_0e0f1011, 2'b00, 2'b00, 0, 0, 0, 2);
    run_fetch(64'h80000204, 8'd0, 2'd3, 0, 1, 64'h76543210_fedcba98, 2'b00, 2'b00, 0, 1, 0, 0);

    // Asynchronous reset while the R channel is open.
    req_valid = 1'b1; req_addr = 64'h80000300; req_len = 0; req_size = 3;
    tick();
    req_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("pre_rst_rready", rready, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_rready", rready, 0);
    check_eq("arst_inst_valid", inst_valid, 0);
    check_eq("arst_araddr", araddr, 0);
    check_eq("arst_req_ready", req_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_req_ready", req_ready, 1);

    for (int k = 0; k < 8; k++) begin
      logic [63:0] a;
      a = {32'h0, 32'h80000000 | ($urandom & 32'h0000fffc)};
      run_fetch(a, 8'($urandom_range(0, 2)), 2'($urandom), $urandom_range(0, 2),
                $urandom_range(1, 3), {$urandom, $urandom}, 2'b00, 2'b00,
                $urandom_range(0, 2), 0, 0, 0);
    end

    tick();
    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
